// File: rtl/ssf_stream_fir_if.sv
// Stream interface for ssf_stream_fir: sample request/capture toward the
// source and the filtered-sample strobe toward the sink.
// master = the filter, slave = the environment (source and sink).
interface ssf_stream_fir_if #(
    parameter int DATA_W = 32
);
    logic                     req_in;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_en;

    modport master (
        output req_in,
        input  in_data,
        output out_data,
        output out_en
    );

    modport slave (
        input  req_in,
        output in_data,
        input  out_data,
        input  out_en
    );
endinterface

// File: rtl/ssf_stream_fir.sv
// Sequential (one MAC per cycle) streaming FIR with optional soft threshold.
// Each sample period: REQ (ask source) -> CAPTURE (take sample) ->
// TAPS x MAC -> OUT (present result), i.e. TAPS+3 cycles.
module ssf_stream_fir #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       mode,
    input  logic [DATA_W-1:0]          thr,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    ssf_stream_fir_if.master           bus
);

    localparam int ADDR_W = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;

    // Output range limits expressed at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, MAC, OUT} state_t;

    state_t                    state, state_nxt;
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [DATA_W-1:0]  x    [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [ADDR_W-1:0]         k;
    logic                      last_tap;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   y_sh;
    logic signed [DATA_W-1:0]  y_sat;
    logic signed [DATA_W+1:0]  y_ext, thr_ext, y_mag, y_thr;

    assign last_tap = (k == ADDR_W'(TAPS - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; en is only consulted when leaving IDLE or OUT.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = REQ;
            REQ:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     state_nxt = en ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered strobes, high exactly while the FSM sits in REQ / OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.req_in <= 1'b0;
            bus.out_en <= 1'b0;
        end else begin
            bus.req_in <= (state_nxt == REQ);
            bus.out_en <= (state_nxt == OUT);
        end
    end

    // Coefficient store; writable only while the filter is parked and disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the coefficient array is deliberately reset so an unprogrammed filter outputs 0.
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_we && state == IDLE && !en &&
                     ({1'b0, coef_addr} < (ADDR_W+1)'(TAPS))) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Delay line: the captured sample becomes x[0], oldest falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) x[i] <= '0;
        end else if (state == CAPTURE) begin
            x[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
        end
    end

    // One product per MAC cycle; the final sum is also fed straight to the output path.
    always_comb begin
        prod    = PROD_W'(coef[k]) * PROD_W'(x[k]);
        acc_sum = acc + ACC_W'(prod);
    end

    // Accumulator and tap index, cleared on entry to MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            k   <= '0;
        end else if (state == CAPTURE) begin
            acc <= '0;
            k   <= '0;
        end else if (state == MAC) begin
            acc <= acc_sum;
            k   <= k + 1'b1;
        end
    end

    // Scale, saturate, then optionally shrink toward zero by thr.
    always_comb begin
        y_sh = acc_sum >>> SHIFT;
        if (y_sh > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
        else if (y_sh < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
        else                   y_sat = y_sh[DATA_W-1:0];

        y_ext   = (DATA_W+2)'(y_sat);
        thr_ext = $signed({2'b00, thr});
        y_mag   = (y_ext < 0) ? -y_ext : y_ext;
        if (y_mag <= thr_ext)  y_thr = '0;
        else if (y_ext > 0)    y_thr = y_ext - thr_ext;
        else                   y_thr = y_ext + thr_ext;
    end

    // Result register, loaded on the MAC->OUT edge and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data <= '0;
        end else if (state == MAC && last_tap) begin
            bus.out_data <= mode ? y_thr[DATA_W-1:0] : y_sat;
        end
    end

endmodule

// File: tb/tb_ssf_stream_fir.sv
// Self-checking bench for ssf_stream_fir (TAPS=4, DATA_W=32, COEF_W=16, SHIFT=0).
// A behavioural model predicts each output from the sample history and the
// programmed coefficients; directed runs pin the model with literal values.
module tb_ssf_stream_fir;

    localparam int DATA_W = 32;
    localparam int COEF_W = 16;
    localparam int TAPS   = 4;
    localparam int SHIFT  = 0;

    localparam longint Y_MAX = 64'sd2147483647;
    localparam longint Y_MIN = -64'sd2147483648;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     en = 1'b0;
    logic                     mode = 1'b0;
    logic [DATA_W-1:0]        thr = '0;
    logic                     coef_we = 1'b0;
    logic [1:0]               coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;

    ssf_stream_fir_if #(.DATA_W(DATA_W)) bus ();

    ssf_stream_fir #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .thr       (thr),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [COEF_W-1:0] mc [TAPS];
    logic signed [DATA_W-1:0] mx [TAPS];
    logic signed [DATA_W-1:0] exp_q [$];
    logic signed [DATA_W-1:0] got_q [$];
    logic signed [DATA_W-1:0] src_q [$];
    int                       oe_cyc [$];
    int                       n_req = 0;
    int                       n_out = 0;
    int                       cyc   = 0;
    logic signed [DATA_W-1:0] src_s;

    function automatic logic signed [DATA_W-1:0] model_out(input logic m, input logic [DATA_W-1:0] t);
        longint s, y, a;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(mc[i]) * longint'(mx[i]);
        y = s >>> SHIFT;
        if (y > Y_MAX) y = Y_MAX;
        else if (y < Y_MIN) y = Y_MIN;
        if (m) begin
            a = (y < 0) ? -y : y;
            if (a <= longint'(t)) y = 0;
            else if (y > 0)       y = y - longint'(t);
            else                  y = y + longint'(t);
        end
        return y[DATA_W-1:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            mc[i] = '0;
            mx[i] = '0;
        end
        exp_q.delete();
        src_q.delete();
    endtask

    always @(posedge clk) cyc++;

    // Source: hands out the next queued sample on the edge that sees req_in.
    always @(posedge clk) begin
        if (rst_n && bus.req_in) begin
            src_s = (src_q.size() > 0) ? src_q.pop_front() : '0;
            n_req++;
            for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = src_s;
            exp_q.push_back(model_out(mode, thr));
            #1 bus.in_data = src_s;
        end
    end

    // Compare process: checks every output strobe against the model.
    logic prev_req = 1'b0;
    logic prev_oe  = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_in) check("req_in_single_cycle", prev_req, 0);
            if (bus.out_en) begin
                check("out_en_single_cycle", prev_oe, 0);
                n_out++;
                got_q.push_back(bus.out_data);
                oe_cyc.push_back(cyc);
                check("model_has_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("out_data_vs_model", bus.out_data, exp_q.pop_front());
            end
        end
        prev_req = bus.req_in;
        prev_oe  = bus.out_en;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_coef(input int a, input logic signed [COEF_W-1:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = a[1:0];
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        mc[a]   = d;
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        wr_coef(0, 16'(c0));
        wr_coef(1, 16'(c1));
        wr_coef(2, 16'(c2));
        wr_coef(3, 16'(c3));
    endtask

    // Run exactly n samples from src_q; optionally hammer coef_we while en=1.
    task automatic run(input int n, input bit we_during);
        int r0, o0, t;
        r0 = n_req;
        o0 = n_out;
        t  = 0;
        @(negedge clk);
        en = 1'b1;
        if (we_during) begin
            coef_we   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 16'sd77;
        end
        while (n_req - r0 < n && t < 8 * n + 20) begin
            @(negedge clk);
            t++;
            if (we_during) begin
                coef_addr = 2'(t);
                coef_data = 16'(t * 1000 - 5000);
            end
        end
        en      = 1'b0;
        coef_we = 1'b0;
        t = 0;
        while (n_out - o0 < n && t < 8 * n + 20) begin
            @(negedge clk);
            t++;
        end
        repeat (15) @(negedge clk);
        check("run_request_count", n_req - r0, n);
        check("run_output_count", n_out - o0, n);
    endtask

    task automatic check_got(input string name, input int idx, input logic signed [DATA_W-1:0] exp);
        if (idx < got_q.size()) check(name, got_q[idx], exp);
        else                    check({name, "_missing"}, got_q.size(), idx + 1);
    endtask

    // Start one sample and wait until the FSM is inside MAC.
    task automatic start_one_into_mac();
        int r0, t;
        r0 = n_req;
        t  = 0;
        @(negedge clk);
        en = 1'b1;
        while (n_req == r0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("start_request_seen", n_req - r0, 1);
        repeat (2) @(negedge clk);
    endtask

    int imp [5] = '{100, 200, 300, 400, 0};
    int thr_exp [4] = '{50, 0, -30, 0};

    initial begin
        bus.in_data = '0;
        model_clear();

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_in", bus.req_in, 0);
        check("reset_out_en", bus.out_en, 0);
        check("reset_out_data", bus.out_data, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_without_en", n_req, 0);

        // Impulse response
        set_coefs(1, 2, 3, 4);
        mode = 1'b0;
        got_q.delete();
        oe_cyc.delete();
        src_q = '{32'sd100, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        run(5, 1'b0);
        for (int i = 0; i < 5; i++) check_got("impulse", i, imp[i]);
        for (int i = 1; i < oe_cyc.size(); i++) check("out_en_spacing", oe_cyc[i] - oe_cyc[i-1], 7);

        // Coefficient writes while enabled are dropped
        got_q.delete();
        src_q = '{32'sd100, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        run(5, 1'b1);
        for (int i = 0; i < 5; i++) check_got("impulse_after_blocked_we", i, imp[i]);

        // Soft threshold
        set_coefs(1, 0, 0, 0);
        mode = 1'b1;
        thr  = 32'd50;
        got_q.delete();
        src_q = '{32'sd100, -32'sd30, -32'sd80, 32'sd50};
        run(4, 1'b0);
        for (int i = 0; i < 4; i++) check_got("soft_threshold", i, thr_exp[i]);
        mode = 1'b0;
        thr  = '0;

        // Saturation, both rails
        set_coefs(32767, 32767, 32767, 32767);
        got_q.delete();
        src_q = '{32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        run(4, 1'b0);
        for (int i = 0; i < 4; i++) check_got("saturate_pos", i, 32'sh7FFFFFFF);
        got_q.delete();
        src_q = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
        run(4, 1'b0);
        check_got("saturate_neg", 3, 32'sh80000000);

        // Randomised runs against the model
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < TAPS; c++) begin
                if (r % 2 == 0) wr_coef(c, 16'(int'($urandom_range(0, 2047)) - 1024));
                else            wr_coef(c, 16'($urandom));
            end
            mode = 1'($urandom_range(0, 1));
            thr  = (r % 3 == 2) ? 32'($urandom) : 32'($urandom_range(0, 5000));
            for (int s = 0; s < 8; s++) begin
                if (r % 2 == 0) src_q.push_back(32'(int'($urandom_range(0, 200000)) - 100000));
                else            src_q.push_back(32'($urandom));
            end
            run(8, 1'b0);
        end
        mode = 1'b0;
        thr  = '0;

        // en dropped mid-MAC: current sample completes, then nothing more
        begin
            int r0, o0;
            set_coefs(1, 0, 0, 0);
            got_q.delete();
            r0 = n_req;
            o0 = n_out;
            src_q = '{32'sd1234};
            start_one_into_mac();
            en = 1'b0;
            repeat (40) @(negedge clk);
            check("en_drop_outputs", n_out - o0, 1);
            check("en_drop_requests", n_req - r0, 1);
            check_got("en_drop_value", 0, 32'sd1234);
        end

        // Asynchronous reset during MAC
        src_q = '{32'sd555};
        start_one_into_mac();
        #2 rst_n = 1'b0;
        en = 1'b0;
        model_clear();
        #1;
        check("async_reset_req_in", bus.req_in, 0);
        check("async_reset_out_en", bus.out_en, 0);
        check("async_reset_out_data", bus.out_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        set_coefs(1, 2, 3, 4);
        got_q.delete();
        src_q = '{32'sd0};
        run(1, 1'b0);
        check_got("first_after_reset", 0, 32'sd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if something wedges.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1);
    end

endmodule

// File: doc/ssf_stream_fir.md
SSF_STREAM_FIR -- requirements
Module: ssf_stream_fir

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning signed sample width of in_data and out_data.
REQ-002 SHALL provide parameter COEF_W, default 16, meaning signed coefficient width.
REQ-003 SHALL provide parameter TAPS, default 8, meaning filter length (2..64).
REQ-004 SHALL provide parameter SHIFT, default 0, meaning arithmetic right shift applied to the accumulator before saturation.
REQ-005 SHALL provide port clk  input  1  the single clock, rising-edge.
REQ-006 SHALL provide port rst_n  input  1  reset; asynchronous and active-low.
REQ-007 SHALL provide port en  input  1  run enable; high = process samples continuously.
REQ-008 SHALL provide port mode  input  1  0 = plain FIR, 1 = FIR followed by soft threshold.
REQ-009 SHALL provide port thr  input  DATA_W  unsigned threshold magnitude, used when mode=1.
REQ-010 SHALL provide port in_data  input  DATA_W  signed sample from the source.
REQ-011 SHALL provide port req_in  output  1  sample request to the source.
REQ-012 SHALL provide port out_data  output  DATA_W  signed filtered sample.
REQ-013 SHALL provide port out_en  output  1  out_data valid strobe.
REQ-014 SHALL provide ports coef_we  input  1, coef_addr  input  clog2(TAPS), coef_data  input  COEF_W: coefficient write port.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, CAPTURE, MAC, OUT.
REQ-016 SHALL transition IDLE->REQ when en=1; remain in IDLE otherwise.
REQ-017 SHALL assert req_in, registered, for exactly the one cycle spent in REQ; the source updates in_data on the rising edge that samples req_in=1.
REQ-018 SHALL, in CAPTURE, sample in_data on the next rising edge and shift it into a TAPS-deep delay line as x[0], discarding x[TAPS-1].
REQ-019 SHALL spend exactly TAPS cycles in MAC, one product coef[k]*x[k] per cycle for k=0..TAPS-1, accumulating in a signed register of DATA_W+COEF_W+clog2(TAPS) bits cleared at MAC entry.
REQ-020 SHALL, on the MAC->OUT transition, compute y = acc >>> SHIFT and saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-021 SHALL, when mode=1, replace y with 0 if |y|<=thr, else y-thr for y>0, else y+thr.
REQ-022 SHALL register out_data and assert out_en for exactly the one cycle in OUT; out_data SHALL hold its value until the next OUT.
REQ-023 SHALL go OUT->REQ if en=1, else OUT->IDLE; a sample period is therefore exactly TAPS+3 cycles.
REQ-024 SHALL, when en falls in REQ, CAPTURE or MAC, complete the current sample through OUT and then enter IDLE.
REQ-025 SHALL sample mode and thr only at the MAC->OUT transition.
REQ-026 SHALL accept coef_we only when state=IDLE and en=0; writes at any other time SHALL be dropped.
REQ-027 SHALL use coef[0] for the newest sample x[0].

Reset
REQ-028 SHALL, on rst_n=0, immediately force state=IDLE, req_in=0, out_en=0, out_data=0, accumulator=0 and all delay-line entries=0, regardless of current state.
REQ-029 SHALL reset all coefficients to 0.
REQ-030 SHALL leave IDLE no earlier than the first rising edge after rst_n rises.

Verification (TAPS=4, DATA_W=32, COEF_W=16, SHIFT=0)
REQ-031 Bench SHALL check reset: rst_n=0 during MAC -> req_in=0, out_en=0, out_data=0 asynchronously; after release, first output with zero input = 0.
REQ-032 Bench SHALL check impulse: coef {1,2,3,4}, mode=0, inputs 100,0,0,0,0 -> out_data 100,200,300,400,0; out_en spacing exactly 7 cycles; req_in one cycle each period.
REQ-033 Bench SHALL check saturation: all coefs 32767, inputs 2^31-1 repeated -> out_data 2147483647; all inputs -2^31 -> out_data -2147483648.
REQ-034 Bench SHALL check soft threshold: mode=1, thr=50, unfiltered y = 100, -30, -80, 50 -> out_data 50, 0, -30, 0.
REQ-035 Bench SHALL check en deassert mid-MAC: current sample still produces one out_en, then no further req_in or out_en while en=0.
REQ-036 Bench SHALL check coefficient write protection: coef_we with en=1 -> coefficients unchanged and impulse response unchanged.
